// File: rtl/wb_mem_responder_if.sv
// rtl/wb_mem_responder_if.sv - Wishbone B4 classic 16-bit bus bundle for wb_mem_responder
// Purpose: groups the request/response signals of the external 16-bit bus.
// Signals:
//   cyc, stb, we   master -> slave  cycle valid, strobe, write enable
//   adr            master -> slave  word address (`WB_ADDR_W bits)
//   sel            master -> slave  byte lanes: [1] = dat[15:8], [0] = dat[7:0]
//   i_dat          master -> slave  write data
//   o_dat          slave  -> master read data
//   ack, err       slave  -> master one-cycle completion pulses
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif
`ifndef WB_DATA_W
`define WB_DATA_W 16
`endif
`ifndef WB_SEL_BITS
`define WB_SEL_BITS 2
`endif

interface wb_mem_responder_if;
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [`WB_ADDR_W-1:0]   adr;
  logic [`WB_SEL_BITS-1:0] sel;
  logic [`WB_DATA_W-1:0]   i_dat;
  logic [`WB_DATA_W-1:0]   o_dat;
  logic                    ack;
  logic                    err;

  modport master (
    output cyc, stb, we, adr, sel, i_dat,
    input  o_dat, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, sel, i_dat,
    output o_dat, ack, err
  );
endinterface

// File: rtl/wb_mem_responder.sv
// rtl/wb_mem_responder.sv - Wishbone B4 classic slave with internal 16-bit word memory
// Purpose: far-end responder of the compressed-bus chain. Decodes an address window,
//   inserts WAIT_CYC wait states, supports byte-lane writes and optional write protection.
// Ports:
//   i_clk  clock, all logic on posedge
//   i_rst  synchronous active-high reset (memory contents are not reset)
//   wb     slave side of wb_mem_responder_if (cyc/stb/we/adr/sel/i_dat in, o_dat/ack/err out)
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif
`ifndef WB_DATA_W
`define WB_DATA_W 16
`endif
`ifndef WB_SEL_BITS
`define WB_SEL_BITS 2
`endif

module wb_mem_responder #(
  parameter int                    MEM_AW    = 8,
  parameter logic [`WB_ADDR_W-1:0] BASE_ADR  = '0,
  parameter int                    WAIT_CYC  = 1,
  parameter bit                    READ_ONLY = 1'b0
) (
  input logic               i_clk,
  input logic               i_rst,
  wb_mem_responder_if.slave wb
);
  localparam int AW = `WB_ADDR_W;
  localparam int DW = `WB_DATA_W;
  localparam int SB = `WB_SEL_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [AW-1:0]   adr_q;
  logic            we_q;
  logic [SB-1:0]   sel_q;
  logic [DW-1:0]   dat_q;
  logic            ack_q;
  logic            err_q;
  logic [DW-1:0]   odat_q;
  logic [DW-1:0]   mem_q [0:(1<<MEM_AW)-1];

  logic [AW-1:0]     req_adr_d;
  logic              req_we_d;
  logic [SB-1:0]     req_sel_d;
  logic [DW-1:0]     req_dat_d;
  logic [MEM_AW-1:0] req_idx_d;
  logic              req_hit_d;
  logic              resp_d;
  logic              wr_d;

  // With no wait states the response is decided on the capture edge itself,
  // so the decision looks at the live bus in IDLE and at the captured copy otherwise.
  always_comb begin
    req_adr_d = adr_q;
    req_we_d  = we_q;
    req_sel_d = sel_q;
    req_dat_d = dat_q;
    if (state_q == S_IDLE) begin
      req_adr_d = wb.adr;
      req_we_d  = wb.we;
      req_sel_d = wb.sel;
      req_dat_d = wb.i_dat;
    end
    req_idx_d = req_adr_d[MEM_AW-1:0];
    req_hit_d = (req_adr_d[AW-1:MEM_AW] == BASE_ADR[AW-1:MEM_AW]);

    // resp_d marks the edge that enters RESP
    resp_d = 1'b0;
    case (state_q)
      S_IDLE:  resp_d = (WAIT_CYC == 0) && wb.cyc && wb.stb;
      S_WAIT:  resp_d = wb.cyc && (cnt_q == 4'd0);
      default: resp_d = 1'b0;
    endcase
    wr_d = resp_d && req_hit_d && req_we_d && !READ_ONLY;
  end

  // Memory is left uninitialised by reset; a reset on the RESP-entry edge cancels the write.
  always_ff @(posedge i_clk) begin
    if (wr_d && !i_rst) begin
      for (int b = 0; b < SB; b++) begin
        if (req_sel_d[b]) begin
          mem_q[req_idx_d][8*b +: 8] <= req_dat_d[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      odat_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (state_q == S_IDLE && wb.cyc && wb.stb) begin
        adr_q <= wb.adr;
        we_q  <= wb.we;
        sel_q <= wb.sel;
        dat_q <= wb.i_dat;
      end
      if (resp_d) begin
        state_q <= S_RESP;
        if (req_hit_d && !(req_we_d && READ_ONLY)) begin
          ack_q <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
        if (req_hit_d && !req_we_d) begin
          odat_q <= mem_q[req_idx_d];
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (wb.cyc && wb.stb) begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(WAIT_CYC - 1);
            end
          end
          S_WAIT: begin
            // cyc dropped while waiting: abandon silently, nothing written
            if (!wb.cyc) begin
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign wb.ack   = ack_q;
  assign wb.err   = err_q;
  assign wb.o_dat = odat_q;
endmodule

// File: tb/tb_wb_mem_responder.sv
// tb/tb_wb_mem_responder.sv - self-checking bench for wb_mem_responder
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif
`ifndef WB_DATA_W
`define WB_DATA_W 16
`endif
`ifndef WB_SEL_BITS
`define WB_SEL_BITS 2
`endif

module tb_wb_mem_responder;
  logic clk = 1'b0;
  logic rst0, rst3, rstr;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  wb_mem_responder_if b0 ();
  wb_mem_responder_if b3 ();
  wb_mem_responder_if br ();

  wb_mem_responder #(.MEM_AW(8), .BASE_ADR('0), .WAIT_CYC(0), .READ_ONLY(1'b0)) u0 (
    .i_clk(clk), .i_rst(rst0), .wb(b0));
  wb_mem_responder #(.MEM_AW(8), .BASE_ADR('0), .WAIT_CYC(3), .READ_ONLY(1'b0)) u3 (
    .i_clk(clk), .i_rst(rst3), .wb(b3));
  wb_mem_responder #(.MEM_AW(8), .BASE_ADR('0), .WAIT_CYC(1), .READ_ONLY(1'b1)) ur (
    .i_clk(clk), .i_rst(rstr), .wb(br));

  typedef struct {
    int          w;
    bit          we;
    logic [23:0] adr;
    logic [1:0]  sel;
    logic [15:0] wdat;
    bit          exp_ack;
    bit          exp_err;
    bit          chk_dat;
    logic [15:0] exp_dat;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input bit c, input bit s, input bit we,
                       input logic [23:0] adr, input logic [1:0] sel, input logic [15:0] d);
    case (w)
      0: begin b0.cyc = c; b0.stb = s; b0.we = we; b0.adr = adr; b0.sel = sel; b0.i_dat = d; end
      1: begin b3.cyc = c; b3.stb = s; b3.we = we; b3.adr = adr; b3.sel = sel; b3.i_dat = d; end
      default: begin br.cyc = c; br.stb = s; br.we = we; br.adr = adr; br.sel = sel; br.i_dat = d; end
    endcase
  endtask

  task automatic sample(input int w, output bit a, output bit e, output logic [15:0] q);
    case (w)
      0: begin a = b0.ack; e = b0.err; q = b0.o_dat; end
      1: begin a = b3.ack; e = b3.err; q = b3.o_dat; end
      default: begin a = br.ack; e = br.err; q = br.o_dat; end
    endcase
  endtask

  // One classic transfer: stb held until ack/err, lat = posedges from request to response.
  task automatic xfer(input int w, input bit we, input logic [23:0] adr, input logic [1:0] sel,
                      input logic [15:0] d, output bit a, output bit e, output logic [15:0] q,
                      output int lat);
    bit done;
    done = 1'b0;
    a = 1'b0; e = 1'b0; q = '0; lat = -1;
    @(negedge clk);
    drive(w, 1'b1, 1'b1, we, adr, sel, d);
    for (int i = 1; i <= 20 && !done; i++) begin
      @(negedge clk);
      sample(w, a, e, q);
      if (a || e) begin
        done = 1'b1;
        lat  = i;
      end
    end
    drive(w, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          a, e;
    logic [15:0] q, r1;
    int          lat, k, last;
    bit          seen;

    rst0 = 1'b1; rst3 = 1'b1; rstr = 1'b1;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0; rstr = 1'b0;

    for (int w = 0; w < 3; w++) begin
      sample(w, a, e, q);
      chk($sformatf("reset_ack_%0d", w), 32'(a), 32'd0);
      chk($sformatf("reset_err_%0d", w), 32'(e), 32'd0);
      chk($sformatf("reset_odat_%0d", w), 32'(q), 32'd0);
    end

    //            w we adr          sel    wdat      ack err chk dat       lat
    vecs.push_back('{0, 1, 24'h000010, 2'b11, 16'hBEEF, 1, 0, 0, 16'h0000, 1});
    vecs.push_back('{0, 0, 24'h000010, 2'b11, 16'h0000, 1, 0, 1, 16'hBEEF, 1});
    vecs.push_back('{0, 1, 24'h000020, 2'b11, 16'h1234, 1, 0, 0, 16'h0000, 1});
    vecs.push_back('{0, 1, 24'h000020, 2'b10, 16'hAB00, 1, 0, 0, 16'h0000, 1});
    vecs.push_back('{0, 0, 24'h000020, 2'b11, 16'h0000, 1, 0, 1, 16'hAB34, 1});
    vecs.push_back('{0, 1, 24'h000020, 2'b00, 16'hFFFF, 1, 0, 0, 16'h0000, 1});
    vecs.push_back('{0, 0, 24'h000020, 2'b01, 16'h0000, 1, 0, 1, 16'hAB34, 1});
    vecs.push_back('{0, 0, 24'h000100, 2'b11, 16'h0000, 0, 1, 1, 16'hAB34, 1});
    vecs.push_back('{0, 1, 24'h000110, 2'b11, 16'h5555, 0, 1, 0, 16'h0000, 1});
    vecs.push_back('{0, 0, 24'h000010, 2'b11, 16'h0000, 1, 0, 1, 16'hBEEF, 1});
    vecs.push_back('{1, 1, 24'h000030, 2'b11, 16'h00C3, 1, 0, 0, 16'h0000, 4});
    vecs.push_back('{1, 0, 24'h000030, 2'b11, 16'h0000, 1, 0, 1, 16'h00C3, 4});
    vecs.push_back('{1, 0, 24'hFFFF30, 2'b11, 16'h0000, 0, 1, 1, 16'h00C3, 4});
    vecs.push_back('{2, 0, 24'h000200, 2'b11, 16'h0000, 0, 1, 1, 16'h0000, 2});

    foreach (vecs[i]) begin
      xfer(vecs[i].w, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdat, a, e, q, lat);
      chk($sformatf("v%0d_ack", i), 32'(a), 32'(vecs[i].exp_ack));
      chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].chk_dat) chk($sformatf("v%0d_dat", i), 32'(q), 32'(vecs[i].exp_dat));
      @(negedge clk);
      sample(vecs[i].w, a, e, q);
      chk($sformatf("v%0d_pulse_width", i), 32'({a, e}), 32'd0);
    end

    // write-protected memory: a rejected write leaves the word as it was
    xfer(2, 1'b0, 24'h000001, 2'b11, '0, a, e, r1, lat);
    chk("ro_read1_ack", 32'(a), 32'd1);
    xfer(2, 1'b1, 24'h000001, 2'b11, ~r1, a, e, q, lat);
    chk("ro_write_err", 32'(e), 32'd1);
    chk("ro_write_ack", 32'(a), 32'd0);
    xfer(2, 1'b0, 24'h000001, 2'b11, '0, a, e, q, lat);
    chk("ro_read2_dat", 32'(q), 32'(r1));

    // abort: cyc dropped during WAIT -> no response, no write
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b1, 24'h000030, 2'b11, 16'h7777);
    repeat (2) @(negedge clk);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sample(1, a, e, q);
      if (a || e) seen = 1'b1;
    end
    chk("abort_no_response", 32'(seen), 32'd0);
    xfer(1, 1'b0, 24'h000030, 2'b11, '0, a, e, q, lat);
    chk("abort_mem_intact", 32'(q), 32'h00C3);

    // reset during WAIT of a write
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b1, 24'h000030, 2'b11, 16'h9999);
    repeat (2) @(negedge clk);
    rst3 = 1'b1;
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    rst3 = 1'b0;
    sample(1, a, e, q);
    chk("rst_wait_ackerr", 32'({a, e}), 32'd0);
    chk("rst_wait_odat", 32'(q), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sample(1, a, e, q);
      if (a || e) seen = 1'b1;
    end
    chk("rst_no_response", 32'(seen), 32'd0);
    xfer(1, 1'b0, 24'h000030, 2'b11, '0, a, e, q, lat);
    chk("rst_idle_lat", 32'(lat), 32'd4);
    chk("rst_mem_intact", 32'(q), 32'h00C3);

    // preload 0..7, then back-to-back reads with stb held throughout
    for (int i = 0; i < 8; i++) begin
      xfer(1, 1'b1, 24'(i), 2'b11, 16'hA000 + 16'(i) * 16'h0101, a, e, q, lat);
      chk($sformatf("preload%0d_ack", i), 32'(a), 32'd1);
    end
    k = 0;
    last = 0;
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b0, 24'h000000, 2'b11, '0);
    for (int t = 0; t < 200 && k < 8; t++) begin
      @(negedge clk);
      sample(1, a, e, q);
      if (e) chk("b2b_err", 32'(e), 32'd0);
      if (a) begin
        chk($sformatf("b2b_dat%0d", k), 32'(q), 32'(16'hA000 + 16'(k) * 16'h0101));
        if (k > 0) chk($sformatf("b2b_spacing%0d", k), 32'(t - last), 32'd5);
        last = t;
        k++;
        if (k < 8) drive(1, 1'b1, 1'b1, 1'b0, 24'(k), 2'b11, '0);
        else drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      end
    end
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    chk("b2b_count", 32'(k), 32'd8);
    @(negedge clk);
    sample(1, a, e, q);
    chk("b2b_final_pulse", 32'({a, e}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
